// File: rtl/lfsr_pattern_gen.sv
// Pseudo-random pattern generator for the BIST path: Fibonacci LFSR emitting a
// programmed number of patterns over valid/ready, plus a bit-serial MSB feed.
module lfsr_pattern_gen #(
  parameter int               WIDTH = 4,
  parameter logic [WIDTH-1:0] TAPS  = 4'b1001,
  parameter int               CNT_W = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] seed,
  input  logic [CNT_W-1:0] length,
  input  logic             ready,
  output logic             valid,
  output logic [WIDTH-1:0] pattern,
  output logic             serial_out,
  output logic             busy,
  output logic             done,
  output logic             seed_err,
  output logic             wrapped
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } fsm_t;

  fsm_t             fsm;
  logic [WIDTH-1:0] lfsr;
  logic [WIDTH-1:0] loaded_seed;
  logic [CNT_W-1:0] remaining;
  logic [WIDTH-1:0] lfsr_next;
  logic [WIDTH-1:0] seed_eff;
  logic             xfer;

  // An all-zero seed would lock the LFSR, so it is replaced by ...0001.
  assign seed_eff  = (seed == '0) ? WIDTH'(1) : seed;
  assign lfsr_next = {lfsr[WIDTH-2:0], ^(lfsr & TAPS)};
  assign xfer      = valid & ready;
  assign pattern   = lfsr;

  // NOTE: every register here updates with <= so all branches read the values
  // from before the edge; blocking assignments would leak new values forward.
  always_ff @(posedge clock) begin
    if (reset) begin
      fsm         <= IDLE;
      lfsr        <= '0;
      loaded_seed <= '0;
      remaining   <= '0;
      valid       <= 1'b0;
      serial_out  <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      seed_err    <= 1'b0;
      wrapped     <= 1'b0;
    end else begin
      case (fsm)
        IDLE: begin
          if (start) begin
            lfsr        <= seed_eff;
            loaded_seed <= seed_eff;
            seed_err    <= (seed == '0);
            wrapped     <= 1'b0;
            remaining   <= length;
            busy        <= 1'b1;
            if (length != '0) begin
              fsm        <= RUN;
              valid      <= 1'b1;
              serial_out <= seed_eff[WIDTH-1];
            end else begin
              fsm  <= DONE;
              done <= 1'b1;
            end
          end
        end

        RUN: begin
          if (xfer) begin
            if (lfsr_next == loaded_seed) wrapped <= 1'b1;
            // Terminating at remaining==1 keeps the counter from ever wrapping.
            if (remaining == CNT_W'(1)) begin
              fsm        <= DONE;
              valid      <= 1'b0;
              serial_out <= 1'b0;
              done       <= 1'b1;
            end else begin
              lfsr       <= lfsr_next;
              remaining  <= remaining - CNT_W'(1);
              serial_out <= lfsr_next[WIDTH-1];
            end
          end
        end

        DONE: begin
          fsm  <= IDLE;
          done <= 1'b0;
          busy <= 1'b0;
        end

        default: begin
          fsm   <= IDLE;
          valid <= 1'b0;
          done  <= 1'b0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lfsr_pattern_gen.sv
// Table-driven bench for lfsr_pattern_gen: each vector drives inputs for one
// cycle and compares all outputs just after the following rising edge.
module tb_lfsr_pattern_gen;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [3:0]  seed = '0;
  logic [15:0] length = '0;
  logic        ready = 1'b0;
  logic        valid, serial_out, busy, done, seed_err, wrapped;
  logic [3:0]  pattern;

  int vec_count = 0;
  int err_count = 0;

  lfsr_pattern_gen dut (
    .clock      (clock),
    .reset      (reset),
    .start      (start),
    .seed       (seed),
    .length     (length),
    .ready      (ready),
    .valid      (valid),
    .pattern    (pattern),
    .serial_out (serial_out),
    .busy       (busy),
    .done       (done),
    .seed_err   (seed_err),
    .wrapped    (wrapped)
  );

  always #5 clock = ~clock;

  typedef struct {
    string       name;
    logic        rst;
    logic        st;
    logic [3:0]  sd;
    logic [15:0] len;
    logic        rdy;
    logic [9:0]  exp;  // {valid, pattern, serial_out, busy, done, seed_err, wrapped}
  } vec_t;

  vec_t vecs[$];

  function automatic logic [9:0] o(logic v, logic [3:0] p, logic s, logic b,
                                   logic d, logic se, logic w);
    return {v, p, s, b, d, se, w};
  endfunction

  function automatic void add(string n, logic rst, logic st, logic [3:0] sd,
                              logic [15:0] len, logic rdy, logic [9:0] exp);
    vec_t x;
    x.name = n; x.rst = rst; x.st = st; x.sd = sd; x.len = len; x.rdy = rdy; x.exp = exp;
    vecs.push_back(x);
  endfunction

  task automatic check(input string name, input logic [9:0] got, input logic [9:0] exp);
    vec_count++;
    if (got !== exp) begin
      err_count++;
      $display("FAIL %s: got v=%b p=%b s=%b b=%b d=%b se=%b w=%b, expected v=%b p=%b s=%b b=%b d=%b se=%b w=%b",
               name, got[9], got[8:5], got[4], got[3], got[2], got[1], got[0],
               exp[9], exp[8:5], exp[4], exp[3], exp[2], exp[1], exp[0]);
    end
  endtask

  task automatic apply(input vec_t x);
    @(negedge clock);
    reset = x.rst; start = x.st; seed = x.sd; length = x.len; ready = x.rdy;
    @(posedge clock);
    #1;
    check(x.name, {valid, pattern, serial_out, busy, done, seed_err, wrapped}, x.exp);
  endtask

  // Maximal sequence of x^4+x^3+1 from seed 0001, worked out by hand.
  logic [3:0] wrap_seq [16] = '{4'h1, 4'h3, 4'h7, 4'hF, 4'hE, 4'hD, 4'hA, 4'h5,
                                4'hB, 4'h6, 4'hC, 4'h9, 4'h2, 4'h4, 4'h8, 4'h1};

  initial begin
    add("reset0", 1, 0, 4'h0, 16'd0, 0, o(0, 4'h0, 0, 0, 0, 0, 0));
    add("reset1", 1, 0, 4'h0, 16'd0, 0, o(0, 4'h0, 0, 0, 0, 0, 0));
    // Basic run, with a start during DONE that must be ignored.
    add("basic_p1",   0, 1, 4'h1, 16'd5, 1, o(1, 4'h1, 0, 1, 0, 0, 0));
    add("basic_p2",   0, 0, 4'h0, 16'd0, 1, o(1, 4'h3, 0, 1, 0, 0, 0));
    add("basic_p3",   0, 0, 4'h0, 16'd0, 1, o(1, 4'h7, 0, 1, 0, 0, 0));
    add("basic_p4",   0, 0, 4'h0, 16'd0, 1, o(1, 4'hF, 1, 1, 0, 0, 0));
    add("basic_p5",   0, 0, 4'h0, 16'd0, 1, o(1, 4'hE, 1, 1, 0, 0, 0));
    add("basic_done", 0, 0, 4'h0, 16'd0, 1, o(0, 4'hE, 0, 1, 1, 0, 0));
    add("basic_idle", 0, 1, 4'h9, 16'd3, 1, o(0, 4'hE, 0, 0, 0, 0, 0));
    add("idle_hold",  0, 0, 4'h0, 16'd0, 1, o(0, 4'hE, 0, 0, 0, 0, 0));
    // Back-pressure after the second pattern.
    add("bp_p1",   0, 1, 4'h1, 16'd5, 1, o(1, 4'h1, 0, 1, 0, 0, 0));
    add("bp_p2",   0, 0, 4'h0, 16'd0, 1, o(1, 4'h3, 0, 1, 0, 0, 0));
    add("bp_hold1", 0, 0, 4'h0, 16'd0, 0, o(1, 4'h3, 0, 1, 0, 0, 0));
    add("bp_hold2", 0, 0, 4'h0, 16'd0, 0, o(1, 4'h3, 0, 1, 0, 0, 0));
    add("bp_hold3", 0, 0, 4'h0, 16'd0, 0, o(1, 4'h3, 0, 1, 0, 0, 0));
    add("bp_p3",   0, 0, 4'h0, 16'd0, 1, o(1, 4'h7, 0, 1, 0, 0, 0));
    add("bp_p4",   0, 0, 4'h0, 16'd0, 1, o(1, 4'hF, 1, 1, 0, 0, 0));
    add("bp_p5",   0, 0, 4'h0, 16'd0, 1, o(1, 4'hE, 1, 1, 0, 0, 0));
    add("bp_done", 0, 0, 4'h0, 16'd0, 1, o(0, 4'hE, 0, 1, 1, 0, 0));
    add("bp_idle", 0, 0, 4'h0, 16'd0, 1, o(0, 4'hE, 0, 0, 0, 0, 0));
    // Zero seed is substituted and flagged; next start clears the flag.
    add("zs_p1",    0, 1, 4'h0, 16'd2, 1, o(1, 4'h1, 0, 1, 0, 1, 0));
    add("zs_p2",    0, 0, 4'h0, 16'd0, 1, o(1, 4'h3, 0, 1, 0, 1, 0));
    add("zs_done",  0, 0, 4'h0, 16'd0, 1, o(0, 4'h3, 0, 1, 1, 1, 0));
    add("zs_idle",  0, 0, 4'h0, 16'd0, 1, o(0, 4'h3, 0, 0, 0, 1, 0));
    add("zs_stick", 0, 0, 4'h0, 16'd0, 1, o(0, 4'h3, 0, 0, 0, 1, 0));
    add("clr_p1",   0, 1, 4'h5, 16'd1, 0, o(1, 4'h5, 0, 1, 0, 0, 0));
    add("clr_hold", 0, 0, 4'h0, 16'd0, 0, o(1, 4'h5, 0, 1, 0, 0, 0));
    add("clr_done", 0, 0, 4'h0, 16'd0, 1, o(0, 4'h5, 0, 1, 1, 0, 0));
    add("clr_idle", 0, 0, 4'h0, 16'd0, 1, o(0, 4'h5, 0, 0, 0, 0, 0));
    // Zero length: straight to DONE, never valid.
    add("zl_done", 0, 1, 4'h3, 16'd0, 1, o(0, 4'h3, 0, 1, 1, 0, 0));
    add("zl_idle", 0, 0, 4'h0, 16'd0, 1, o(0, 4'h3, 0, 0, 0, 0, 0));
    // Start held during RUN is ignored; reset after the third pattern aborts.
    add("mr_p1",   0, 1, 4'h1, 16'd5, 1, o(1, 4'h1, 0, 1, 0, 0, 0));
    add("mr_p2",   0, 1, 4'h9, 16'd2, 1, o(1, 4'h3, 0, 1, 0, 0, 0));
    add("mr_p3",   0, 1, 4'h9, 16'd2, 1, o(1, 4'h7, 0, 1, 0, 0, 0));
    add("mr_rst",  1, 0, 4'h0, 16'd0, 1, o(0, 4'h0, 0, 0, 0, 0, 0));
    add("mr_idle", 0, 0, 4'h0, 16'd0, 1, o(0, 4'h0, 0, 0, 0, 0, 0));
    add("fr_p1",   0, 1, 4'h1, 16'd5, 1, o(1, 4'h1, 0, 1, 0, 0, 0));
    add("fr_p2",   0, 0, 4'h0, 16'd0, 1, o(1, 4'h3, 0, 1, 0, 0, 0));
    add("fr_p3",   0, 0, 4'h0, 16'd0, 1, o(1, 4'h7, 0, 1, 0, 0, 0));
    add("fr_p4",   0, 0, 4'h0, 16'd0, 1, o(1, 4'hF, 1, 1, 0, 0, 0));
    add("fr_p5",   0, 0, 4'h0, 16'd0, 1, o(1, 4'hE, 1, 1, 0, 0, 0));
    add("fr_done", 0, 0, 4'h0, 16'd0, 1, o(0, 4'hE, 0, 1, 1, 0, 0));
    add("fr_idle", 0, 0, 4'h0, 16'd0, 1, o(0, 4'hE, 0, 0, 0, 0, 0));

    for (int i = 0; i < vecs.size(); i++) apply(vecs[i]);

    // Wrap-around: full period plus one, wrapped rises on the 15th transfer.
    begin
      vec_t x;
      x.rst = 0; x.sd = 4'h1; x.len = 16'd16; x.rdy = 1;
      for (int i = 0; i < 16; i++) begin
        x.name = $sformatf("wrap_p%0d", i + 1);
        x.st   = (i == 0);
        x.exp  = o(1, wrap_seq[i], wrap_seq[i][3], 1, 0, 0, (i == 15));
        apply(x);
      end
      x.st = 0;
      x.name = "wrap_done"; x.exp = o(0, 4'h1, 0, 1, 1, 0, 1); apply(x);
      x.name = "wrap_idle"; x.exp = o(0, 4'h1, 0, 0, 0, 0, 1); apply(x);
      x.name = "wrap_clr";  x.st = 1; x.sd = 4'h5; x.len = 16'd1; x.rdy = 0;
      x.exp = o(1, 4'h5, 0, 1, 0, 0, 0); apply(x);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec_count, err_count);
    $finish;
  end

endmodule
